// File: rtl/pc_next_unit.sv
// Fetch-stage next-PC generator: prioritised redirects, a pending-redirect buffer
// for redirects raised under stall, and a direct-mapped BTB for taken prediction.
module pc_next_unit #(
  parameter int              XLEN         = 32,
  parameter int              NUM_REDIR    = 2,
  parameter int              BTB_ENTRIES  = 16,
  parameter bit              BTB_EN       = 1'b1,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic [NUM_REDIR-1:0]      redir_valid,
  input  logic [NUM_REDIR*XLEN-1:0] redir_target,
  input  logic                      upd_valid,
  input  logic [XLEN-1:0]           upd_pc,
  input  logic [XLEN-1:0]           upd_target,
  input  logic                      upd_taken,
  output logic [XLEN-1:0]           pc,
  output logic [XLEN-1:0]           next_pc,
  output logic                      pred_taken,
  output logic                      redir_pending
);

  localparam int              IDX        = $clog2(BTB_ENTRIES);
  localparam int              TAG_W      = XLEN - IDX - 2;
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic {RUN, HOLD} state_t;

  state_t          state, state_nxt;
  logic            redir_any;
  logic [XLEN-1:0] redir_tgt;
  logic [XLEN-1:0] pend_tgt, pend_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic            pred_nxt;
  logic            from_btb;
  logic            btb_hit;
  logic [XLEN-1:0] btb_target;

  // NOTE: combinational processes use blocking '=' so later statements see the
  // updated value; scanning from the top index down lets the lowest index win.
  always_comb begin
    redir_any = 1'b0;
    redir_tgt = '0;
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (redir_valid[i]) begin
        redir_any = 1'b1;
        redir_tgt = redir_target[i*XLEN +: XLEN];
      end
    end
    redir_tgt = redir_tgt & ALIGN_MASK;
  end

  if (BTB_EN) begin : g_btb
    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]       btb_tag [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_tgt [BTB_ENTRIES];
    logic [IDX-1:0]         rd_idx, wr_idx;
    logic                   upd_unused;

    assign rd_idx     = pc[IDX+1:2];
    assign wr_idx     = upd_pc[IDX+1:2];
    assign upd_unused = ^upd_pc[1:0];
    // Lookup reads the pre-update entry: no write-to-read bypass.
    assign btb_hit    = btb_valid[rd_idx] && (btb_tag[rd_idx] == pc[XLEN-1:IDX+2]);
    assign btb_target = btb_tgt[rd_idx];

    always_ff @(posedge clk) begin
      if (rst) begin
        btb_valid <= '0;
      end else if (upd_valid) begin
        if (upd_taken)
          btb_valid[wr_idx] <= 1'b1;
        else if (btb_tag[wr_idx] == upd_pc[XLEN-1:IDX+2])
          btb_valid[wr_idx] <= 1'b0;
      end
    end

    // NOTE: tag/target storage is not reset; the valid bits alone qualify it,
    // which keeps the arrays mappable onto plain RAM.
    always_ff @(posedge clk) begin
      if (upd_valid && upd_taken) begin
        btb_tag[wr_idx] <= upd_pc[XLEN-1:IDX+2];
        btb_tgt[wr_idx] <= upd_target & ALIGN_MASK;
      end
    end
  end else begin : g_no_btb
    logic upd_unused;
    assign upd_unused = ^{upd_valid, upd_pc, upd_target, upd_taken};
    assign btb_hit    = 1'b0;
    assign btb_target = '0;
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    from_btb  = 1'b0;
    state_nxt = state;
    pend_nxt  = pend_tgt;
    pc_nxt    = pc;
    pred_nxt  = pred_taken;

    if (redir_any)
      next_pc = redir_tgt;
    else if (state == HOLD)
      next_pc = pend_tgt;
    else if (btb_hit) begin
      next_pc  = btb_target;
      from_btb = 1'b1;
    end else
      next_pc = pc + XLEN'(4);

    case (state)
      RUN: begin
        if (!stall) begin
          pc_nxt   = next_pc;
          pred_nxt = from_btb;
        end else if (redir_any) begin
          pend_nxt  = redir_tgt;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (stall) begin
          if (redir_any) pend_nxt = redir_tgt;
        end else begin
          pc_nxt    = next_pc;
          pred_nxt  = 1'b0;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      pc         <= RESET_VECTOR;
      pred_taken <= 1'b0;
      pend_tgt   <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      pred_taken <= pred_nxt;
      pend_tgt   <= pend_nxt;
    end
  end

  assign redir_pending = (state == HOLD);

endmodule
